// File: rtl/seq_mult_4bit.sv
// Sequential shift-and-add unsigned multiplier.
// Performs one add/shift step per clock; WIDTH steps per product, then a
// one-cycle DONE state that presents the registered product on P.
module seq_mult_4bit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  // Counter holds 0..WIDTH so it can never wrap inside one operation.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   m;        // latched multiplicand
  logic [WIDTH-1:0]   h;        // high half of the accumulator
  logic [WIDTH-1:0]   q;        // low half: multiplier bits shifting out
  logic [CW-1:0]      cnt;      // iterations completed so far
  logic [WIDTH:0]     sum;      // partial sum including carry-out
  logic               carry;
  logic               last;     // this CALC edge performs the final iteration
  logic [2*WIDTH-1:0] hq_next;  // {c,H',Q} shifted right by one

  // Add-and-shift datapath for one iteration.
  always_comb begin
    sum     = {1'b0, h} + (q[0] ? {1'b0, m} : '0);
    carry   = sum[WIDTH];
    hq_next = {carry, sum[WIDTH-1:0], q[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    // NOTE: every output gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and product register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m   <= '0;
      h   <= '0;
      q   <= '0;
      cnt <= '0;
      P   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= A;
            q   <= B;
            h   <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          {h, q} <= hq_next;
          cnt    <= cnt + CW'(1);
          if (last) P <= hq_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_4bit.sv
// Self-checking bench for seq_mult_4bit: scoreboard of expected products
// pushed at the accepting edge, popped and compared when done pulses.
module tb_seq_mult_4bit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] p;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_done = 1'b0;

  seq_mult_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: done width, product and latency against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("done_width", done, 1'b0);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("product", P, e.p);
        check("latency", cyc - e.acc, 4);
      end
    end
    prev_done <= done;
  end

  // Record an accepted operation; called #1 after the accepting edge.
  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.p   = a * b;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // One isolated multiply with busy profile checks.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b;
    for (int i = 0; i < 4; i++) begin
      check("busy_calc", busy, 1'b1);
      @(negedge clk);
    end
    check("busy_in_done", busy, 1'b0);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst_P", P, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;

    // Basic operation then asynchronous reset with no clock edge.
    do_op(4'd3, 4'd5);
    check("p_before_reset", P, 8'h0F);
    #2 reset = 1'b1;
    #1;
    check("async_rst_P", P, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Corner operands.
    do_op(4'd15, 4'd15);
    do_op(4'd0, 4'd9);
    do_op(4'd9, 4'd0);

    // Start held high: back-to-back products, inputs disturbed during CALC.
    @(negedge clk);
    A = 4'd7; B = 4'd6; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      push_exp(4'd7, 4'd6);
      repeat (3) begin
        @(negedge clk);
        A = 4'($urandom_range(0, 15));
        B = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      A = 4'd7; B = 4'd6;
      if (i == 2) start = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (6) @(negedge clk);

    // Reset during the second CALC cycle abandons the operation.
    @(negedge clk);
    A = 4'd12; B = 4'd11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_P", P, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abandon_P", P, 8'h00);
    do_op(4'd12, 4'd11);
    check("after_rst_P", P, 8'h84);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b));
      end
    end

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
